sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Memory-side responder for the M0/M1 single-port word memory interface driven by the convolution engines: R_req, addr, R_data, W_req[3:0], W_data.
- Holds a DEPTH x 32 word array with per-byte write enables, registered read data and a configurable read pipeline.
- Gives the engine a bit-exact image/kernel source (M0) and result sink (M1), with access counters for bench checking.

Parameters:
- DEPTH, 1024, number of 32-bit words; byte addresses 0 .. 4*DEPTH-1 are valid.
- READ_LATENCY, 1, edges from request sample to R_data update; legal values 1..4.
- CNT_W, 16, width of the read/write access counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- R_req  input  1  read request, sampled each edge.
- addr  input  32  byte address; word index = addr[31:2]; addr[1:0] ignored.
- R_data  output  32  read data (registered).
- R_valid  output  1  high for one cycle when R_data carries a new read result.
- W_req  input  4  byte write enables; bit b writes W_data[8b+7:8b].
- W_data  input  32  write data.
- rd_cnt  output  CNT_W  accepted reads, saturating.
- wr_cnt  output  CNT_W  accepted writes (W_req != 0), saturating.
- err  output  1  sticky out-of-range flag (exists only with ADDR_CHECK_EN; otherwise tied 0).

Behaviour:
- Reset (rst=1 at an edge):
  - R_data=0, R_valid=0, rd_cnt=0, wr_cnt=0, err=0.
  - All read pipeline stages cleared; in-flight reads are discarded and produce no R_valid.
  - Array contents are not cleared.
  - Requests presented during a reset edge are ignored.
- Write:
  - Happens at the edge where W_req != 0 and the word index is < DEPTH.
  - Only enabled bytes change; partial masks such as 4'b0011 preserve the upper bytes.
  - wr_cnt increments by 1 per accepted write, regardless of how many bytes are enabled.
- Read:
  - At the edge where R_req=1 and the index is < DEPTH, the word is fetched into stage 1.
  - The read is read-first: if a write hits the same word on the same edge, the pre-write value is returned. The new value is visible to reads sampled on later edges.
  - rd_cnt increments at the sample edge.
- Latency:
  - READ_LATENCY=1: R_data/R_valid update at the same sampling edge, so data is visible in the following cycle.
  - READ_LATENCY=N: R_data/R_valid update N-1 edges later.
  - The pipeline accepts one read per cycle (full throughput); results come out in request order.
- Idle: when no read completes, R_data holds its last value and R_valid=0.
- Simultaneous read and write in the same cycle: both are accepted; both counters increment.
- Out-of-range index (>= DEPTH):
  - Write is dropped.
  - Read still completes, with R_data=0 and R_valid=1.
  - Neither counter increments.
- Counters: saturate at all-ones and never wrap.
- Pipeline state: one 32-bit data register plus a valid bit per stage, shift each edge, no stall input.

Optional Feature:
- Macro: SRAM_RESPONDER_ADDR_CHECK_EN.
- Defined:
  - err is set at the first edge carrying an out-of-range read or write, or a request with addr[1:0] != 0.
  - err stays set until rst.
  - Misaligned accesses still execute, using addr[31:2].
- Undefined: no check logic is built; err is constant 0.

Test Plan:
- Write 0x12345678, W_req=4'b1111, addr 0x10; then read addr 0x10 -> with READ_LATENCY=1, R_data=0x12345678 and R_valid=1 one cycle after the request; wr_cnt=1, rd_cnt=1.
- Word at 0x20 = 0xAABBCCDD; write W_data=0x11223344 with W_req=4'b0101 -> readback 0xAA22CC44.
- READ_LATENCY=2, read back-to-back addresses 0x0, 0x4, 0x8 (words 5, 6, 7) -> R_data=5, 6, 7 on consecutive cycles, first one 2 cycles after the first request, with no gaps.
- Same edge: R_req=1 and W_req=4'b1111, W_data=0x99, addr 0x40 (old value 0x7) -> R_data=0x7; a read on the next cycle returns 0x99.
- DEPTH=1024, read addr 0x1000 and write addr 0x1004 -> R_data=0, counters unchanged, memory unchanged; with ADDR_CHECK_EN, err=1 and it stays 1 until rst.
- Assert rst while 3 reads are in flight (READ_LATENCY=4) -> no R_valid pulses afterwards, R_data=0, counters=0, previously written data still readable.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder
//   Memory-side responder for the single-port word memory interface used by
//   the convolution engines (image/kernel source on M0, result sink on M1).
//   Holds a DEPTH x 32 word array with per-byte write enables, read-first
//   semantics and a READ_LATENCY-stage registered read pipeline.
//
//   Optional build macro: SRAM_RESPONDER_ADDR_CHECK_EN
//     defined   -> err is a sticky flag for out-of-range or misaligned requests
//     undefined -> err is constant 0 and no check logic is built
//
// Ports
//   clk      clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   R_req    read request, sampled each edge
//   addr     byte address; word index = addr[31:2]
//   R_data   registered read data, holds its last value between reads
//   R_valid  one-cycle pulse when R_data carries a new read result
//   W_req    byte write enables; bit b writes W_data[8b+7:8b]
//   W_data   write data
//   rd_cnt   accepted (in-range) reads, saturating
//   wr_cnt   accepted (in-range, W_req != 0) writes, saturating
//   err      sticky address-check flag (0 unless the macro is defined)

module sram_responder #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             R_req,
    input  logic [31:0]      addr,
    output logic [31:0]      R_data,
    output logic             R_valid,
    input  logic [3:0]       W_req,
    input  logic [31:0]      W_data,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          in_range;
    logic          rd_acc;
    logic          wr_acc;

    assign word_idx = addr[31:2];
    assign mem_idx  = word_idx[AW-1:0];
    // Compare the full word index so aliases above DEPTH are rejected.
    assign in_range = ({2'b00, word_idx} < 32'(DEPTH));
    assign rd_acc   = R_req && in_range;
    assign wr_acc   = (W_req != 4'b0000) && in_range;

    // NOTE: the array has no reset; contents survive rst and only the control
    // state is cleared. Writes are still gated so a reset edge ignores requests.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (W_req[b]) begin
                    mem[mem_idx][8*b +: 8] <= W_data[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline. Stage 0 captures the array at the sample edge; later
    // stages shift every edge. Data registers only load behind a valid bit so
    // the last stage (R_data) holds its value while no read completes.
    logic [31:0]             pipe_data  [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking here makes the read see the pre-write word
            // when a write hits the same address on the same edge (read-first).
            pipe_valid[0] <= R_req;
            if (R_req) begin
                pipe_data[0] <= in_range ? mem[mem_idx] : 32'h0;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign R_data  = pipe_data[READ_LATENCY-1];
    assign R_valid = pipe_valid[READ_LATENCY-1];

    // Saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_acc && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (wr_acc && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SRAM_RESPONDER_ADDR_CHECK_EN
    logic err_q;
    logic bad_req;

    // Misaligned requests still execute; they only raise the flag.
    assign bad_req = (R_req || (W_req != 4'b0000)) &&
                     (!in_range || (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_req) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

    localparam int DEPTH = 1024;
    localparam int RL    = 3;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             R_req;
    logic [31:0]      addr;
    logic [31:0]      R_data;
    logic             R_valid;
    logic [3:0]       W_req;
    logic [31:0]      W_data;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             err;

    sram_responder #(
        .DEPTH(DEPTH),
        .READ_LATENCY(RL),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .R_req(R_req),
        .addr(addr),
        .R_data(R_data),
        .R_valid(R_valid),
        .W_req(W_req),
        .W_data(W_data),
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array, counters and expected-response queue.
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          m_rd;
    int          m_wr;
    logic        m_err;
    logic [31:0] last_rdata;
    bit          mon_en = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (R_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_r_valid", {31'b0, R_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("r_data", R_data, e.data);
                    check("r_latency", cyc, e.due);
                    last_rdata = e.data;
                end
            end else begin
                check("r_data_hold", R_data, last_rdata);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    check("r_valid_missing", {31'b0, R_valid}, 32'h1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic check_state();
        check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
        check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        check("err", {31'b0, err}, {31'b0, m_err});
    endtask

    // One bus cycle: drive, update the model, then check counters after the edge.
    // Called at posedge+#1 and returns at the next posedge+#1.
    task automatic op(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        int   idx;
        bit   inr;
        exp_t e;
        R_req  = r;
        W_req  = w;
        addr   = a;
        W_data = d;
        idx = int'(a >> 2);
        inr = (a >> 2) < DEPTH;
        if (r) begin
            e.data = inr ? model[idx] : 32'h0;
            e.due  = cyc + RL;
            sb.push_back(e);
            if (inr && m_rd < CNT_MAX) m_rd++;
        end
        if (w != 4'b0000 && inr) begin
            for (int b = 0; b < 4; b++)
                if (w[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            if (m_wr < CNT_MAX) m_wr++;
        end
`ifdef SRAM_RESPONDER_ADDR_CHECK_EN
        if ((r || w != 4'b0000) && (!inr || a[1:0] != 2'b00)) m_err = 1'b1;
`endif
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        R_req = 1'b0;
        W_req = 4'b0000;
        addr  = 32'h0;
        W_data = 32'h0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset edge with a request presented: the request must be ignored and all
    // in-flight reads discarded.
    task automatic do_reset();
        rst    = 1'b1;
        R_req  = 1'b1;
        W_req  = 4'b1111;
        addr   = 32'h10;
        W_data = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        sb.delete();
        last_rdata = 32'h0;
        m_rd  = 0;
        m_wr  = 0;
        m_err = 1'b0;
        rst   = 1'b0;
        R_req = 1'b0;
        W_req = 4'b0000;
        check("reset_r_valid", {31'b0, R_valid}, 32'h0);
        check("reset_r_data", R_data, 32'h0);
        check_state();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        R_req = 1'b0;
        W_req = 4'b0000;
        addr = 32'h0;
        W_data = 32'h0;
        m_rd = 0;
        m_wr = 0;
        m_err = 1'b0;
        last_rdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_r_valid", {31'b0, R_valid}, 32'h0);
        check("init_r_data", R_data, 32'h0);
        check_state();
        mon_en = 1;

        // Basic write then read.
        op(1'b0, 4'b1111, 32'h10, 32'h12345678);
        op(1'b1, 4'b0000, 32'h10, 32'h0);
        idle(RL);
        check("basic_word", model[4], 32'h12345678);

        // Partial byte mask keeps unselected bytes.
        op(1'b0, 4'b1111, 32'h20, 32'hAABBCCDD);
        op(1'b0, 4'b0101, 32'h20, 32'h11223344);
        op(1'b1, 4'b0000, 32'h20, 32'h0);
        check("byte_mask_model", model[8], 32'hAA22CC44);

        // Back-to-back reads must come out on consecutive cycles.
        op(1'b0, 4'b1111, 32'h0, 32'd5);
        op(1'b0, 4'b1111, 32'h4, 32'd6);
        op(1'b0, 4'b1111, 32'h8, 32'd7);
        op(1'b1, 4'b0000, 32'h0, 32'h0);
        op(1'b1, 4'b0000, 32'h4, 32'h0);
        op(1'b1, 4'b0000, 32'h8, 32'h0);
        idle(RL + 1);

        // Read-first on a same-edge read/write collision.
        op(1'b0, 4'b1111, 32'h40, 32'h7);
        op(1'b1, 4'b1111, 32'h40, 32'h99);
        op(1'b1, 4'b0000, 32'h40, 32'h0);
        idle(RL);

        // Out-of-range read and write, then confirm the aliased word is intact.
        op(1'b1, 4'b0000, 32'h1000, 32'h0);
        op(1'b0, 4'b1111, 32'h1004, 32'hFFFF_FFFF);
        op(1'b1, 4'b0000, 32'h4, 32'h0);
        idle(RL + 2);

        // Fill a working set, then random traffic.
        for (int i = 0; i < 64; i++) op(1'b0, 4'b1111, 32'(i * 4), $urandom);
        for (int i = 0; i < 400; i++) begin
            int          idx;
            logic        r;
            logic [3:0]  w;
            r   = 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            idx = ($urandom_range(0, 15) == 0) ? DEPTH + $urandom_range(0, 100)
                                               : $urandom_range(0, 63);
            op(r, w, 32'(idx * 4 + $urandom_range(0, 3)), $urandom);
        end

        // Reset with reads in flight; memory must survive.
        op(1'b1, 4'b0000, 32'h10, 32'h0);
        op(1'b1, 4'b0000, 32'h14, 32'h0);
        op(1'b1, 4'b0000, 32'h18, 32'h0);
        do_reset();
        idle(RL + 2);
        op(1'b1, 4'b0000, 32'h10, 32'h0);
        op(1'b1, 4'b0000, 32'h14, 32'h0);
        op(1'b1, 4'b0000, 32'h18, 32'h0);
        idle(RL + 2);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
